// File: rtl/led_fade_pkg.sv
// led_fade_pkg
// Shared types and defaults for the LED fade output stage.
//   chan_state_e : per-channel fade state (OFF, RISE, ON, FALL)
//   DEFAULT_*    : default PWM width, prescaler divide and step size
//   maxLevel()   : full-brightness level for a given PWM width
package led_fade_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } chan_state_e;

  localparam int DEFAULT_PWM_BITS  = 8;
  localparam int DEFAULT_STEP_DIV  = 48828;
  localparam int DEFAULT_STEP_SIZE = 1;

  function automatic int maxLevel(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_fade_driver_channel.sv
// fade_channel
// One LED channel: saturating level ramp toward 0 or MAX, the fade FSM and
// the registered PWM output stage.
// Optional macro LED_FADE_GAMMA_EN selects a squared duty curve; otherwise
// the duty equals the level.
// Ports:
//   clock_i      clock
//   reset_ni     asynchronous active-low reset
//   stepTick_i   one-cycle strobe that advances the ramp and FSM
//   target_i     1 = fade toward MAX, 0 = fade toward 0
//   pwmCnt_i     shared free-running PWM counter
//   led_o        registered PWM output
//   inMotion_o   high while the channel is in RISE or FALL
module fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int STEP_SIZE = DEFAULT_STEP_SIZE
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                stepTick_i,
  input  logic                target_i,
  input  logic [PWM_BITS-1:0] pwmCnt_i,
  output logic                led_o,
  output logic                inMotion_o
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL = PWM_BITS'(maxLevel(PWM_BITS));
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(STEP_SIZE);

  chan_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS:0]   levelW, targetW, sumW, floorW, diffW;

  // Ramp arithmetic is one bit wider than the level so that adding or
  // subtracting the step can be clamped at the target instead of wrapping.
  always_comb begin
    levelW  = {1'b0, level_q};
    targetW = target_i ? {1'b0, MAX_LEVEL} : '0;
    sumW    = levelW + STEP_W;
    floorW  = targetW + STEP_W;
    diffW   = levelW - STEP_W;
    level_d = level_q;
    if (levelW < targetW) begin
      level_d = (sumW > targetW) ? targetW[PWM_BITS-1:0] : sumW[PWM_BITS-1:0];
    end else if (levelW > targetW) begin
      level_d = (levelW >= floorW) ? diffW[PWM_BITS-1:0] : targetW[PWM_BITS-1:0];
    end
  end

  // The state follows the level that this tick produces, so a ramp that
  // reaches its end point settles on the same tick as the final step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF: begin
        if (target_i) state_d = (level_d == MAX_LEVEL) ? ON : RISE;
      end
      RISE: begin
        if (!target_i)                  state_d = (level_d == '0) ? OFF : FALL;
        else if (level_d == MAX_LEVEL)  state_d = ON;
      end
      ON: begin
        if (!target_i) state_d = (level_d == '0) ? OFF : FALL;
      end
      FALL: begin
        if (target_i)             state_d = (level_d == MAX_LEVEL) ? ON : RISE;
        else if (level_d == '0)   state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] levelSq;

  // Squared perceptual curve: keep the upper half of level*level.
  always_comb begin
    levelSq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    duty    = PWM_BITS'(levelSq >> PWM_BITS);
  end
`else
  always_comb begin
    duty = level_q;
  end
`endif

  // Level and state move only on a step tick; the LED is re-evaluated every
  // cycle, forced fully on or off at the ends of the range.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= OFF;
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      if (stepTick_i) begin
        level_q <= level_d;
        state_q <= state_d;
      end
      if (level_q == MAX_LEVEL) begin
        led_q <= 1'b1;
      end else if (level_q == '0) begin
        led_q <= 1'b0;
      end else begin
        led_q <= (pwmCnt_i < duty);
      end
    end
  end

  assign led_o      = led_q;
  assign inMotion_o = (state_q == RISE) || (state_q == FALL);

endmodule

// File: rtl/led_fade_driver.sv
// led_fade_driver
// Board LED output stage: turns per-LED on/off vectors into smooth PWM fades.
// Optional macro LED_FADE_GAMMA_EN (handled in fade_channel) selects a
// squared duty curve.
// Ports:
//   CLOCK_50   50 MHz system clock
//   RESET_N    asynchronous active-low reset
//   in_green   target on/off vector, green bank
//   in_red     target on/off vector, red bank
//   enable     1 = fades advance, 0 = levels frozen (PWM keeps running)
//   LEDG       PWM-driven green LEDs
//   LEDR       PWM-driven red LEDs
//   busy       high while any channel is mid-fade
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int STEP_DIV  = DEFAULT_STEP_DIV,
  parameter int STEP_SIZE = DEFAULT_STEP_SIZE
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_LEDS-1:0] in_green,
  input  logic [NUM_LEDS-1:0] in_red,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] LEDG,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                busy
);

  localparam int               CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0]      stepCnt_q, stepCnt_d;
  logic [PWM_BITS-1:0]   pwmCnt_q;
  logic [NUM_LEDS-1:0]   green_q, red_q;
  logic                  busy_q;
  logic                  stepTick;
  logic [2*NUM_LEDS-1:0] target, ledBits, inMotion;

  // The prescaler only advances while enabled, so a frozen fade resumes
  // with the same tick spacing it had when it stopped.
  always_comb begin
    stepTick  = enable && (stepCnt_q == STEP_LAST);
    stepCnt_d = stepCnt_q;
    if (enable) begin
      stepCnt_d = (stepCnt_q == STEP_LAST) ? '0 : stepCnt_q + 1'b1;
    end
  end

  // Input capture, free-running PWM counter and the aggregated busy flag.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      stepCnt_q <= '0;
      pwmCnt_q  <= '0;
      green_q   <= '0;
      red_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      stepCnt_q <= stepCnt_d;
      pwmCnt_q  <= pwmCnt_q + 1'b1;
      green_q   <= in_green;
      red_q     <= in_red;
      busy_q    <= |inMotion;
    end
  end

  assign target = {red_q, green_q};

  for (genvar i = 0; i < 2*NUM_LEDS; i++) begin : gChan
    fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .STEP_SIZE (STEP_SIZE)
    ) uChan (
      .clock_i    (CLOCK_50),
      .reset_ni   (RESET_N),
      .stepTick_i (stepTick),
      .target_i   (target[i]),
      .pwmCnt_i   (pwmCnt_q),
      .led_o      (ledBits[i]),
      .inMotion_o (inMotion[i])
    );
  end

  assign LEDG = ledBits[NUM_LEDS-1:0];
  assign LEDR = ledBits[2*NUM_LEDS-1:NUM_LEDS];
  assign busy = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver
// Directed bench for led_fade_driver with PWM_BITS=4, STEP_DIV=4.
// dut uses STEP_SIZE=1, dutSat uses STEP_SIZE=4.
// Brightness is observed by freezing the fade (enable=0) and counting how
// many of 16 consecutive cycles each LED is high.
module tb_led_fade_driver;

  logic       clock;
  logic       RESET_N;
  logic       enable;
  logic [7:0] inGreen, inRed, satGreen, satRed;
  logic [7:0] ledG, ledR, satLedG, satLedR;
  logic       busy, satBusy;

  int checks   = 0;
  int failures = 0;
  int hiG [8];
  int hiR [8];
  int hiS [8];
  int frozenBusy;
  int firstBusy;

  led_fade_driver #(
    .NUM_LEDS(8), .PWM_BITS(4), .STEP_DIV(4), .STEP_SIZE(1)
  ) dut (
    .CLOCK_50 (clock),
    .RESET_N  (RESET_N),
    .in_green (inGreen),
    .in_red   (inRed),
    .enable   (enable),
    .LEDG     (ledG),
    .LEDR     (ledR),
    .busy     (busy)
  );

  led_fade_driver #(
    .NUM_LEDS(8), .PWM_BITS(4), .STEP_DIV(4), .STEP_SIZE(4)
  ) dutSat (
    .CLOCK_50 (clock),
    .RESET_N  (RESET_N),
    .in_green (satGreen),
    .in_red   (satRed),
    .enable   (enable),
    .LEDG     (satLedG),
    .LEDR     (satLedR),
    .busy     (satBusy)
  );

  // 10 time-unit clock; everything is driven and sampled on the falling edge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected high cycles out of 16 for a frozen level (MAX=15).
  function automatic int expHigh(input int lvl);
    if (lvl >= 15) return 16;
    if (lvl <= 0)  return 0;
`ifdef LED_FADE_GAMMA_EN
    return (lvl * lvl) >> 4;
`else
    return lvl;
`endif
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] g, input logic [7:0] r, input logic [7:0] s);
    inGreen  = g;
    inRed    = r;
    satGreen = s;
  endtask

  // Called on a falling edge where the prescaler is at 0; leaves it at 0.
  task automatic runTicks(input int n);
    repeat (4 * n) @(negedge clock);
  endtask

  // Freeze fades, skip two cycles so the LED register reflects the frozen
  // level, count high cycles, then resume with the prescaler still at 0.
  task automatic measureAll(input int cycles);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      hiG[i] = 0;
      hiR[i] = 0;
      hiS[i] = 0;
    end
    repeat (cycles) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        hiG[i] += int'(ledG[i]);
        hiR[i] += int'(ledR[i]);
        hiS[i] += int'(satLedG[i]);
      end
    end
    frozenBusy = int'(busy);
    enable = 1'b1;
  endtask

  initial begin
    int satUp [5];
    int satDn [5];
    int others;
    satUp = '{4, 8, 12, 15, 15};
    satDn = '{11, 7, 3, 0, 0};

    RESET_N = 1'b0;
    enable  = 1'b1;
    satRed  = 8'h00;
    applyStimulus(8'hFF, 8'hFF, 8'hFF);
    repeat (3) @(negedge clock);
    checkOutput("reset_ledg", int'(ledG), 0);
    checkOutput("reset_ledr", int'(ledR), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_sat_ledg", int'(satLedG), 0);

    // Rise to full on green[0].
    RESET_N = 1'b1;
    applyStimulus(8'h01, 8'h00, 8'h00);
    firstBusy = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (busy && firstBusy == 0) firstBusy = i;
    end
    checkOutput("busy_rise_latency", firstBusy, 5);
    measureAll(16);
    checkOutput("rise_lvl2_g0", hiG[0], expHigh(2));
    checkOutput("rise_lvl2_g1", hiG[1], 0);
    checkOutput("rise_lvl2_r0", hiR[0], 0);

    // Duty check at level 5 over two PWM periods.
    runTicks(3);
    measureAll(32);
    checkOutput("duty_lvl5_g0", hiG[0], 2 * expHigh(5));
    checkOutput("duty_frozen_busy", frozenBusy, 1);
    measureAll(16);
    checkOutput("duty_lvl5_hold", hiG[0], expHigh(5));

    runTicks(9);
    checkOutput("busy_lvl14", int'(busy), 1);
    repeat (4) @(negedge clock);
    checkOutput("busy_at_last_step", int'(busy), 1);
    @(negedge clock);
    checkOutput("busy_fall_after_full", int'(busy), 0);
    repeat (3) @(negedge clock);
    measureAll(16);
    checkOutput("full_g0_const", hiG[0], 16);
    others = 0;
    for (int i = 1; i < 8; i++) others += hiG[i];
    for (int i = 0; i < 8; i++) others += hiR[i];
    checkOutput("full_others_off", others, 0);

    // Reversal on red[7].
    applyStimulus(8'h01, 8'h80, 8'h00);
    runTicks(8);
    measureAll(16);
    checkOutput("rev_up_lvl8", hiR[7], expHigh(8));
    checkOutput("rev_up_busy", frozenBusy, 1);
    applyStimulus(8'h01, 8'h00, 8'h00);
    runTicks(1);
    measureAll(16);
    checkOutput("rev_lvl7", hiR[7], expHigh(7));
    runTicks(4);
    measureAll(16);
    checkOutput("rev_lvl3", hiR[7], expHigh(3));
    runTicks(2);
    measureAll(16);
    checkOutput("rev_lvl1", hiR[7], expHigh(1));
    checkOutput("rev_lvl1_busy", frozenBusy, 1);
    repeat (4) @(negedge clock);
    checkOutput("rev_busy_last_step", int'(busy), 1);
    @(negedge clock);
    checkOutput("rev_busy_fall", int'(busy), 0);
    repeat (3) @(negedge clock);
    runTicks(2);
    measureAll(16);
    checkOutput("rev_no_overshoot", hiR[7], 0);
    checkOutput("rev_g0_still_full", hiG[0], 16);

    // Saturation with STEP_SIZE=4 on all eight green LEDs.
    applyStimulus(8'h01, 8'h00, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      runTicks(1);
      measureAll(16);
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("sat_up%0d_led%0d", k, i), hiS[i], expHigh(satUp[k]));
    end
    applyStimulus(8'h01, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      runTicks(1);
      measureAll(16);
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("sat_dn%0d_led%0d", k, i), hiS[i], expHigh(satDn[k]));
    end

    // Asynchronous reset in the middle of a ramp on green[1].
    applyStimulus(8'h02, 8'h00, 8'h00);
    runTicks(6);
    checkOutput("pre_reset_busy", int'(busy), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("async_reset_ledg", int'(ledG), 0);
    checkOutput("async_reset_ledr", int'(ledR), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clock);
    checkOutput("reset_held_busy", int'(busy), 0);
    RESET_N = 1'b1;
    runTicks(3);
    measureAll(16);
    checkOutput("restart_g1_lvl3", hiG[1], expHigh(3));
    checkOutput("restart_g0_off", hiG[0], 0);
    checkOutput("restart_sat_off", hiS[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
